// File: rtl/fetch_cycle_ctrl.sv
// Instruction-fetch stage and IF/ID register: owns PCF and keeps one imem request in flight.
// A response is dropped after a redirect, or held in a buffer while Decode stalls.
module fetch_cycle_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [1:0]  dbg_state_o
);
    // imem handshake: a request transfers in the cycle imem_req & imem_gnt are both high.
    // The single response is the one cycle where imem_rvalid is high while S_WAIT or S_DROP.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        deliver;
    logic        accept;
    logic [31:0] dlv_instr;
    logic [31:0] dlv_pc;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        deliver      = 1'b0;
        dlv_instr    = hold_instr_q;
        dlv_pc       = hold_pc_q;
        accept       = ~StallD & ~FlushD;
        imem_req     = (state_q == S_REQ) & ~StallF & ~PCSrcE & ~reset;

        case (state_q)
            S_REQ: begin
                if (imem_req && imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (PCSrcE) begin
                    state_d = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    deliver   = 1'b1;
                    dlv_instr = imem_rdata;
                    dlv_pc    = pcf_q;
                    if (accept) begin
                        state_d = S_REQ;
                    end else begin
                        state_d      = S_HOLD;
                        hold_instr_d = imem_rdata;
                        hold_pc_d    = pcf_q;
                    end
                end
            end
            S_HOLD: begin
                if (PCSrcE) begin
                    state_d = S_REQ;
                end else begin
                    deliver = 1'b1;
                    if (accept) state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over StallF and over any sequential advance.
        if (PCSrcE) begin
            pcf_d = PCTargetE;
        end else if (deliver && accept) begin
            pcf_d = dlv_pc + 32'd4;
        end
    end

    always_comb begin
        instr_d = NOP_INSTR;
        pcd_d   = 32'd0;
        pc4_d   = 32'd0;
        valid_d = 1'b0;
        if (FlushD) begin
            instr_d = NOP_INSTR;
        end else if (StallD) begin
            instr_d = instr_q;
            pcd_d   = pcd_q;
            pc4_d   = pc4_q;
            valid_d = valid_q;
        end else if (deliver) begin
            instr_d = dlv_instr;
            pcd_d   = dlv_pc;
            pc4_d   = dlv_pc + 32'd4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            pcf_q        <= RESET_PC;
            hold_instr_q <= 32'd0;
            hold_pc_q    <= 32'd0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_addr   = pcf_q;
    assign InstrD      = instr_q;
    assign PCD         = pcd_q;
    assign PCPlus4D    = pc4_q;
    assign ValidD      = valid_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_fetch_cycle_ctrl.sv
// Bench for fetch_cycle_ctrl: directed scenarios followed by random hazards and memory timing,
// all checked against a request-ownership model (outstanding PC queue, stale flag, held instr).
module tb_fetch_cycle_ctrl;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic        StallF = 1'b0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Model: PCs of granted-but-unanswered requests, and a decoded-but-unaccepted instruction.
    logic [31:0] exp_q[$];
    logic        m_stale;
    logic        m_held;
    logic [31:0] m_held_instr, m_held_pc;
    logic [31:0] m_pc;
    logic [31:0] e_instr, e_pcd, e_pc4;
    logic        e_valid;

    fetch_cycle_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clock(clock), .reset(reset),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_req();
        return (exp_q.size() == 0) && !m_held && !StallF && !PCSrcE;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_stale = 1'b0;
        m_held = 1'b0;
        m_held_instr = 32'd0;
        m_held_pc = 32'd0;
        m_pc = RESET_PC;
        e_instr = NOP_INSTR;
        e_pcd = 32'd0;
        e_pc4 = 32'd0;
        e_valid = 1'b0;
    endtask

    task automatic model_step();
        logic        req, deliver, go;
        logic [31:0] d_instr, d_pc;
        req = model_req();
        go = !StallD && !FlushD;
        deliver = 1'b0;
        d_instr = 32'd0;
        d_pc = 32'd0;
        if (exp_q.size() != 0) begin
            if (imem_rvalid) begin
                d_pc = exp_q.pop_front();
                if (!m_stale && !PCSrcE) begin
                    deliver = 1'b1;
                    d_instr = imem_rdata;
                end
            end else if (PCSrcE) begin
                m_stale = 1'b1;
            end
        end else if (m_held) begin
            if (PCSrcE) begin
                m_held = 1'b0;
            end else begin
                deliver = 1'b1;
                d_instr = m_held_instr;
                d_pc = m_held_pc;
            end
        end
        if (deliver) begin
            if (go) begin
                m_held = 1'b0;
                m_pc = d_pc + 32'd4;
            end else begin
                m_held = 1'b1;
                m_held_instr = d_instr;
                m_held_pc = d_pc;
            end
        end
        if (PCSrcE) m_pc = PCTargetE;
        if (req && imem_gnt) begin
            exp_q.push_back(m_pc);
            m_stale = 1'b0;
        end
        if (FlushD || (!StallD && !deliver)) begin
            e_instr = NOP_INSTR;
            e_pcd = 32'd0;
            e_pc4 = 32'd0;
            e_valid = 1'b0;
        end else if (!StallD) begin
            e_instr = d_instr;
            e_pcd = d_pc;
            e_pc4 = d_pc + 32'd4;
            e_valid = 1'b1;
        end
    endtask

    task automatic check_outputs();
        check_eq("InstrD", InstrD, e_instr);
        check_eq("PCD", PCD, e_pcd);
        check_eq("PCPlus4D", PCPlus4D, e_pc4);
        check_eq("ValidD", ValidD, e_valid);
    endtask

    task automatic run_cycle(input logic pcsrc, input logic [31:0] tgt, input logic sf,
                             input logic sd, input logic fd, input logic gnt,
                             input logic rv, input logic [31:0] rd);
        @(negedge clock);
        PCSrcE = pcsrc;
        PCTargetE = tgt;
        StallF = sf;
        StallD = sd;
        FlushD = fd;
        imem_gnt = gnt;
        imem_rvalid = rv;
        imem_rdata = rd;
        #1;
        check_eq("imem_req", imem_req, model_req());
        check_eq("imem_addr", imem_addr, m_pc);
        @(posedge clock);
        model_step();
        #1;
        check_outputs();
    endtask

    // Reset lands mid-cycle so the asynchronous path is exercised.
    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b1;
        PCSrcE = 1'b0;
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        imem_gnt = 1'b1;
        imem_rvalid = 1'b0;
        model_reset();
        #1;
        check_eq("rst_imem_req", imem_req, 1'b0);
        check_eq("rst_imem_addr", imem_addr, RESET_PC);
        check_outputs();
        repeat (2) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        imem_gnt = 1'b0;
    endtask

    initial begin
        logic        r_pcsrc, r_rv;
        logic [31:0] r_tgt;
        model_reset();
        apply_reset();

        // First fetch with zero-wait memory.
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 32'h0050_0093);
        check_eq("first_instr", InstrD, 32'h0050_0093);
        check_eq("first_pcd", PCD, 32'd0);
        check_eq("first_pc4", PCPlus4D, 32'd4);
        check_eq("first_valid", ValidD, 1'b1);
        check_eq("first_next_addr", imem_addr, 32'd4);

        // Fetch PC 4, then redirect while PC 8 is in flight.
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(1, 32'h100, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
        check_eq("drop_valid", ValidD, 1'b0);
        check_eq("drop_next_addr", imem_addr, 32'h100);

        // Redirect in the same cycle as the response.
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(1, 32'h200, 0, 0, 0, 0, 1, 32'h3333_3333);
        check_eq("same_valid", ValidD, 1'b0);
        check_eq("same_next_addr", imem_addr, 32'h200);

        // Decode stall across the response for PC 12.
        run_cycle(1, 32'hC, 0, 0, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 1, 0, 1, 1, 32'hDEAD_BEEF);
        run_cycle(0, 0, 0, 1, 0, 1, 1, 32'h4444_4444);
        run_cycle(0, 0, 0, 1, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check_eq("stall_instr", InstrD, 32'hDEAD_BEEF);
        check_eq("stall_pcd", PCD, 32'd12);
        check_eq("stall_valid", ValidD, 1'b1);
        check_eq("stall_next_addr", imem_addr, 32'd16);

        // Flush of a valid entry, then fetch stall in S_REQ.
        run_cycle(0, 0, 0, 0, 1, 0, 0, 0);
        check_eq("flush_instr", InstrD, NOP_INSTR);
        check_eq("flush_valid", ValidD, 1'b0);
        run_cycle(0, 0, 1, 0, 0, 1, 0, 0);
        check_eq("stallf_addr", imem_addr, 32'd16);

        // Wrap-around of PC+4.
        run_cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        run_cycle(0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
        check_eq("wrap_pc4", PCPlus4D, 32'd0);
        check_eq("wrap_next_addr", imem_addr, 32'd0);

        // Reset while a response is outstanding.
        run_cycle(0, 0, 0, 0, 0, 1, 0, 0);
        apply_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) apply_reset();
            r_pcsrc = ($urandom_range(0, 99) < 10);
            r_tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if (exp_q.size() != 0) r_rv = ($urandom_range(0, 99) < 55);
            else r_rv = ($urandom_range(0, 99) < 10);
            run_cycle(r_pcsrc, r_tgt,
                      ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 25),
                      ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 70),
                      r_rv, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
